// File: rtl/enemy_dir_ctrl_if.sv
// rtl/enemy_dir_ctrl_if.sv - frame/collision inputs and direction-key outputs of enemy_dir_ctrl
interface enemy_dir_ctrl_if;
  logic       startOfFrame;
  logic       enable;
  logic       column_collision;
  logic [3:0] HitEdgeCode;
  logic       up_direction_key;
  logic       down_direction_key;
  logic       left_direction_key;
  logic       right_direction_key;
  logic [1:0] current_dir;
  logic [7:0] turn_count;

  modport master (
    output startOfFrame, enable, column_collision, HitEdgeCode,
    input  up_direction_key, down_direction_key, left_direction_key, right_direction_key,
    input  current_dir, turn_count
  );

  modport slave (
    input  startOfFrame, enable, column_collision, HitEdgeCode,
    output up_direction_key, down_direction_key, left_direction_key, right_direction_key,
    output current_dir, turn_count
  );
endinterface

// File: rtl/enemy_dir_ctrl.sv
// rtl/enemy_dir_ctrl.sv - enemy wander controller: hold a direction, turn on wall hits or timeouts
module enemy_dir_ctrl #(
  parameter logic [1:0]  INIT_DIR     = 2'd1,
  parameter int          HOLD_FRAMES  = 16,
  parameter int          STALL_FRAMES = 2,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input logic             clk,
  input logic             resetN,
  enemy_dir_ctrl_if.slave bus
);
  localparam int HOLD_W  = (HOLD_FRAMES < 1) ? 1 : $clog2(HOLD_FRAMES + 1);
  localparam int STALL_W = (STALL_FRAMES < 1) ? 1 : $clog2(STALL_FRAMES + 1);
  localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(HOLD_FRAMES);
  localparam logic [STALL_W-1:0] STALL_LOAD = STALL_W'(STALL_FRAMES);
  localparam logic [15:0]        LFSR_TAPS  = 16'hB400;

  typedef enum logic [1:0] {IDLE_ST, MOVE_ST, TURN_ST, STALL_ST} state_t;

  state_t              state_q, state_d;
  logic [1:0]          dir_q, dir_d;
  logic [7:0]          turn_cnt_q, turn_cnt_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [STALL_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic                hit_flag_q, hit_flag_d;
  logic                hit_cause_q, hit_cause_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [3:0]          keys_q, keys_d;  // {up, down, left, right}

  logic [3:0] lead_code;
  logic       lead_hit;
  logic [1:0] rand_dir;

  // Only the edge the sprite is travelling into counts as a wall hit.
  always_comb begin
    lead_code = 4'b0000;
    case (dir_q)
      2'd0: lead_code = 4'b1000;
      2'd1: lead_code = 4'b0100;
      2'd2: lead_code = 4'b0001;
      2'd3: lead_code = 4'b0010;
      default: lead_code = 4'b0000;
    endcase
  end

  assign lead_hit = bus.column_collision && (bus.HitEdgeCode == lead_code);
  assign rand_dir = lfsr_q[1:0];

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    turn_cnt_d  = turn_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    stall_cnt_d = stall_cnt_q;
    hit_flag_d  = hit_flag_q;
    hit_cause_d = hit_cause_q;
    lfsr_d      = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);

    case (state_q)
      IDLE_ST: begin
        if (bus.startOfFrame && bus.enable) begin
          state_d    = MOVE_ST;
          dir_d      = INIT_DIR;
          hold_cnt_d = HOLD_LOAD;
        end
      end
      MOVE_ST: begin
        if (bus.startOfFrame) begin
          if (hit_flag_q || lead_hit) begin
            state_d     = TURN_ST;
            hit_cause_d = 1'b1;
          end else if (hold_cnt_q == '0) begin
            state_d     = TURN_ST;
            hit_cause_d = 1'b0;
          end else begin
            hold_cnt_d = hold_cnt_q - HOLD_W'(1);
          end
        end else if (lead_hit) begin
          hit_flag_d = 1'b1;
        end
      end
      TURN_ST: begin
        if (hit_cause_q) begin
          dir_d       = lfsr_q[0] ? (dir_q - 2'd1) : (dir_q + 2'd1);
          state_d     = STALL_ST;
          stall_cnt_d = STALL_LOAD;
        end else begin
          // A random pick that would reverse the sprite keeps the old heading.
          if (rand_dir != dir_q + 2'd2) begin
            dir_d = rand_dir;
          end
          state_d = MOVE_ST;
        end
        hold_cnt_d = HOLD_LOAD;
        hit_flag_d = 1'b0;
        if (turn_cnt_q != 8'hFF) begin
          turn_cnt_d = turn_cnt_q + 8'd1;
        end
      end
      STALL_ST: begin
        if (bus.startOfFrame) begin
          if (stall_cnt_q != '0) begin
            stall_cnt_d = stall_cnt_q - STALL_W'(1);
          end
          if (stall_cnt_q <= STALL_W'(1)) begin
            state_d = MOVE_ST;
          end
        end
      end
      default: state_d = IDLE_ST;
    endcase

    if (state_q != IDLE_ST && !bus.enable) begin
      state_d    = IDLE_ST;
      hit_flag_d = 1'b0;
      dir_d      = dir_q;
      turn_cnt_d = turn_cnt_q;
    end
  end

  // Keys are decoded from the next state so they line up with the state register.
  always_comb begin
    keys_d = 4'b0000;
    if (state_d == MOVE_ST) begin
      case (dir_d)
        2'd0: keys_d = 4'b1000;
        2'd1: keys_d = 4'b0001;
        2'd2: keys_d = 4'b0100;
        2'd3: keys_d = 4'b0010;
        default: keys_d = 4'b0000;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q     <= IDLE_ST;
      dir_q       <= INIT_DIR;
      turn_cnt_q  <= '0;
      hold_cnt_q  <= HOLD_LOAD;
      stall_cnt_q <= '0;
      hit_flag_q  <= 1'b0;
      hit_cause_q <= 1'b0;
      lfsr_q      <= LFSR_SEED;
      keys_q      <= '0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      turn_cnt_q  <= turn_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      hit_flag_q  <= hit_flag_d;
      hit_cause_q <= hit_cause_d;
      lfsr_q      <= lfsr_d;
      keys_q      <= keys_d;
    end
  end

  assign bus.up_direction_key    = keys_q[3];
  assign bus.down_direction_key  = keys_q[2];
  assign bus.left_direction_key  = keys_q[1];
  assign bus.right_direction_key = keys_q[0];
  assign bus.current_dir         = dir_q;
  assign bus.turn_count          = turn_cnt_q;
endmodule
